// File: rtl/prio_encoder_rr.sv
// Parametrised request encoder with fixed-priority or round-robin selection and a registered valid/ready output.
// Define ENC_MULTI_FLAG_EN to add the 'multi' output (accepted vector had more than one bit set).
module prio_encoder_rr #(
   parameter int  WIDTH  = 8,
   parameter int  MODE   = 0,
   localparam int CODE_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  data,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [CODE_W-1:0] code,
   output logic              zero,
   output logic              code_valid,
   input  logic              code_ready
`ifdef ENC_MULTI_FLAG_EN
   ,
   output logic              multi
`endif
);

   localparam logic [CODE_W:0]   WIDTH_W  = (CODE_W+1)'(WIDTH);
   localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(WIDTH - 1);
   localparam logic [CODE_W-1:0] IDX_ZERO = {CODE_W{1'b0}};
   localparam logic [CODE_W-1:0] IDX_ONE  = CODE_W'(1'b1);
   localparam logic [WIDTH-1:0]  DATA_ONE = WIDTH'(1'b1);

   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] ptr_q, ptr_d;
   logic              zero_q, zero_d;
   logic              valid_q, valid_d;
   logic              multi_q, multi_d;

   logic [CODE_W-1:0] base_s;
   logic [CODE_W:0]   scan_sum_s;
   logic [CODE_W-1:0] scan_idx_s;
   logic [CODE_W-1:0] sel_code_s;
   logic              sel_found_s;
   logic              multi_s;
   logic              accept_s;

   // Fixed priority is round-robin with the search origin pinned to bit 0.
   assign base_s     = (MODE == 32'sd1) ? ptr_q : IDX_ZERO;
   assign data_ready = !valid_q || code_ready;
   assign accept_s   = data_valid && data_ready;
   assign multi_s    = |(data & (data - DATA_ONE));

   // Scan every position once, starting at base_s and wrapping past the top bit.
   always_comb begin
      sel_found_s = 1'b0;
      sel_code_s  = IDX_ZERO;
      scan_sum_s  = {(CODE_W+1){1'b0}};
      scan_idx_s  = IDX_ZERO;
      for (int i = 0; i < WIDTH; i++) begin
         scan_sum_s = {1'b0, base_s} + (CODE_W+1)'(i);
         if (scan_sum_s >= WIDTH_W) begin
            scan_sum_s = scan_sum_s - WIDTH_W;
         end else begin
            scan_sum_s = scan_sum_s;
         end
         scan_idx_s = scan_sum_s[CODE_W-1:0];
         if (!sel_found_s && data[scan_idx_s]) begin
            sel_found_s = 1'b1;
            sel_code_s  = scan_idx_s;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Next-state: capture on accept, drop valid on a plain drain, otherwise hold.
   always_comb begin
      code_d  = code_q;
      zero_d  = zero_q;
      valid_d = valid_q;
      multi_d = multi_q;
      ptr_d   = ptr_q;
      if (accept_s) begin
         valid_d = 1'b1;
         zero_d  = !sel_found_s;
         code_d  = sel_found_s ? sel_code_s : IDX_ZERO;
         multi_d = multi_s;
         if ((MODE == 32'sd1) && sel_found_s) begin
            if (sel_code_s == LAST_IDX) begin
               ptr_d = IDX_ZERO;
            end else begin
               ptr_d = sel_code_s + IDX_ONE;
            end
         end else begin
            ptr_d = ptr_q;
         end
      end else if (code_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q  <= IDX_ZERO;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         ptr_q   <= IDX_ZERO;
      end else begin
         code_q  <= code_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         ptr_q   <= ptr_d;
      end
   end

   assign code       = code_q;
   assign zero       = zero_q;
   assign code_valid = valid_q;
`ifdef ENC_MULTI_FLAG_EN
   assign multi      = multi_q;
`else
   logic unused_multi_s;
   assign unused_multi_s = multi_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (W8 fixed, W8 round-robin, W5 round-robin) checked against a reference model.
module tb_prio_encoder_rr;

   typedef struct {
      logic [7:0] data;
      int         code;
      bit         zero;
      bit         multi;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] din [3];
   logic       dv  [3];
   logic       cr  [3];
   logic       rdy [3];
   logic [2:0] cd  [3];
   logic       zr  [3];
   logic       vld [3];
`ifdef ENC_MULTI_FLAG_EN
   logic       mlt [3];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   int mw [3] = '{8, 8, 5};
   int mm [3] = '{0, 1, 1};
   bit m_valid [3];
   int m_code  [3];
   bit m_zero  [3];
   bit m_multi [3];
   int m_ptr   [3];

   prio_encoder_rr #(.WIDTH(8), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .data(din[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
      .code(cd[0]), .zero(zr[0]), .code_valid(vld[0]), .code_ready(cr[0])
`ifdef ENC_MULTI_FLAG_EN
      , .multi(mlt[0])
`endif
   );

   prio_encoder_rr #(.WIDTH(8), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .data(din[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
      .code(cd[1]), .zero(zr[1]), .code_valid(vld[1]), .code_ready(cr[1])
`ifdef ENC_MULTI_FLAG_EN
      , .multi(mlt[1])
`endif
   );

   prio_encoder_rr #(.WIDTH(5), .MODE(1)) dut2 (
      .clk(clk), .rst(rst), .data(din[2][4:0]), .data_valid(dv[2]), .data_ready(rdy[2]),
      .code(cd[2]), .zero(zr[2]), .code_valid(vld[2]), .code_ready(cr[2])
`ifdef ENC_MULTI_FLAG_EN
      , .multi(mlt[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference selection: first set bit met when walking from the origin modulo w.
   function automatic int pick(logic [7:0] v, int w, int mode, int ptr);
      int i;
      for (int k = 0; k < w; k++) begin
         i = (mode == 1) ? (ptr + k) % w : k;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One clock: check ready before the edge, advance the model, check registered outputs after.
   task automatic step();
      int p;
      bit acc;
      #1;
      for (int d = 0; d < 3; d++)
         chk($sformatf("ready%0d", d), int'(rdy[d]), int'(!m_valid[d] || cr[d]));
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_valid[d] = 0; m_code[d] = 0; m_zero[d] = 0; m_multi[d] = 0; m_ptr[d] = 0;
         end else begin
            acc = dv[d] && (!m_valid[d] || cr[d]);
            if (acc) begin
               p = pick(din[d], mw[d], mm[d], m_ptr[d]);
               m_valid[d] = 1;
               m_zero[d]  = (p < 0);
               m_code[d]  = (p < 0) ? 0 : p;
               m_multi[d] = ($countones(din[d]) > 1);
               if (mm[d] == 1 && p >= 0) m_ptr[d] = (p + 1) % mw[d];
            end else if (cr[d]) begin
               m_valid[d] = 0;
            end
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("valid%0d", d), int'(vld[d]), int'(m_valid[d]));
         chk($sformatf("code%0d", d),  int'(cd[d]),  m_code[d]);
         chk($sformatf("zero%0d", d),  int'(zr[d]),  int'(m_zero[d]));
`ifdef ENC_MULTI_FLAG_EN
         chk($sformatf("multi%0d", d), int'(mlt[d]), int'(m_multi[d]));
`endif
      end
   endtask

   task automatic run_table(int d, vec_t t[$]);
      for (int i = 0; i < t.size(); i++) begin
         din[d] = t[i].data;
         dv[d]  = 1'b1;
         step();
         chk($sformatf("tbl%0d_valid[%0d]", d, i), int'(vld[d]), 1);
         chk($sformatf("tbl%0d_code[%0d]", d, i),  int'(cd[d]),  t[i].code);
         chk($sformatf("tbl%0d_zero[%0d]", d, i),  int'(zr[d]),  int'(t[i].zero));
`ifdef ENC_MULTI_FLAG_EN
         chk($sformatf("tbl%0d_multi[%0d]", d, i), int'(mlt[d]), int'(t[i].multi));
`endif
      end
      dv[d] = 1'b0;
      step();
   endtask

   initial begin
      vec_t t0[$];
      vec_t t1[$];
      for (int k = 0; k < 8; k++) t0.push_back('{8'(1 << k), k, 1'b0, 1'b0});
      t0.push_back('{8'h00, 0, 1'b1, 1'b0});
      t0.push_back('{8'hA4, 2, 1'b0, 1'b1});
      t0.push_back('{8'h10, 4, 1'b0, 1'b0});
      t1.push_back('{8'h85, 0, 1'b0, 1'b1});
      t1.push_back('{8'h85, 2, 1'b0, 1'b1});
      t1.push_back('{8'h85, 7, 1'b0, 1'b1});
      t1.push_back('{8'h85, 0, 1'b0, 1'b1});
      t1.push_back('{8'h00, 0, 1'b1, 1'b0});
      t1.push_back('{8'h05, 2, 1'b0, 1'b1});

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         din[d] = 8'h00; dv[d] = 1'b0; cr[d] = 1'b1;
      end
      step();
      step();
      chk("reset_valid", int'(vld[0]), 0);
      chk("reset_code",  int'(cd[0]),  0);
      chk("reset_zero",  int'(zr[0]),  0);
      rst = 1'b0;
      step();
      step();
      chk("idle_valid", int'(vld[1]), 0);

      run_table(0, t0);
      run_table(1, t1);

      // Back-pressure: a result held for three cycles while a new input waits.
      din[0] = 8'h08; dv[0] = 1'b1;
      step();
      chk("bp_first_code", int'(cd[0]), 3);
      cr[0]  = 1'b0;
      din[0] = 8'h40;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_code",  int'(cd[0]),  3);
         chk("bp_hold_valid", int'(vld[0]), 1);
         chk("bp_hold_ready", int'(rdy[0]), 0);
      end
      cr[0] = 1'b1;
      #1;
      chk("bp_release_ready", int'(rdy[0]), 1);
      step();
      chk("bp_next_code",  int'(cd[0]),  6);
      chk("bp_next_valid", int'(vld[0]), 1);
      dv[0] = 1'b0;
      step();

      // Randomised traffic on all three instances.
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 3; d++) begin
            din[d] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) din[d] = 8'h00;
            if (d == 2) din[d] = din[d] & 8'h1F;
            dv[d] = ($urandom_range(0, 3) != 0);
            cr[d] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      for (int d = 0; d < 3; d++) begin
         dv[d] = 1'b0; cr[d] = 1'b1;
      end
      step();

      // Width 5 wrap, then reset mid-stream restarts the search at index 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      din[2] = 8'h11; dv[2] = 1'b1;
      step();
      chk("w5_code_a", int'(cd[2]), 0);
      step();
      chk("w5_code_b", int'(cd[2]), 4);
      step();
      chk("w5_code_c", int'(cd[2]), 0);
      rst = 1'b1;
      step();
      chk("w5_rst_valid", int'(vld[2]), 0);
      chk("w5_rst_code",  int'(cd[2]),  0);
      rst = 1'b0;
      step();
      chk("w5_after_rst_code", int'(cd[2]), 0);
      step();
      chk("w5_after_rst_next", int'(cd[2]), 4);
      dv[2] = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
